// File: rtl/ball_dir_ctrl_if.sv
// ----------------------------------------------------------------------------
// ball_dir_ctrl_if
// Bundle of the signals between the rules controller and its neighbours
// (paddle logic, ball-position register, display and score logic).
//   start, tick       : game start level and one-cycle move strobe
//   pos               : packed ball position {x, y}
//   lpad_y, rpad_y    : top rows of the left/right paddles
//   vector            : motion vector {dx, dy} for the position register
//   en                : 1 = ball moves, 0 = position register recentres
//   score_l, score_r  : running scores
//   point_l, point_r  : one-cycle scoring pulses
//   game_over         : high while the game is finished
// The slave modport is the controller; master is the surrounding system.
// ----------------------------------------------------------------------------
interface ball_dir_ctrl_if #(
    parameter int BIT_OF_WIDTH = 3
);
    logic                        start;
    logic                        tick;
    logic [2*BIT_OF_WIDTH-1:0]   pos;
    logic [BIT_OF_WIDTH-1:0]     lpad_y;
    logic [BIT_OF_WIDTH-1:0]     rpad_y;
    logic [3:0]                  vector;
    logic                        en;
    logic [3:0]                  score_l;
    logic [3:0]                  score_r;
    logic                        point_l;
    logic                        point_r;
    logic                        game_over;

    modport master (
        output start, tick, pos, lpad_y, rpad_y,
        input  vector, en, score_l, score_r, point_l, point_r, game_over
    );

    modport slave (
        input  start, tick, pos, lpad_y, rpad_y,
        output vector, en, score_l, score_r, point_l, point_r, game_over
    );
endinterface

// File: rtl/ball_dir_ctrl.sv
// ----------------------------------------------------------------------------
// ball_dir_ctrl
// Direction and rules controller for the ball. From the ball position and
// both paddle positions it produces the per-step motion vector, handles wall
// and paddle bounces, detects misses, keeps score and ends the game.
// Ports:
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   io_bus   : ball_dir_ctrl_if.slave (see interface header for signals)
// ----------------------------------------------------------------------------
module ball_dir_ctrl #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int PADDLE_LEN   = 3,
    parameter int WIN_SCORE    = 9,
    parameter int HOLD_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst_n,
    ball_dir_ctrl_if.slave io_bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = BIT_OF_WIDTH + 1;

    localparam logic [1:0] D_POS  = 2'b01;
    localparam logic [1:0] D_NEG  = 2'b11;
    localparam logic [3:0] SERVE0 = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_dir;
    logic [3:0]              r_vector;
    logic                    r_en;
    logic [3:0]              r_score_l;
    logic [3:0]              r_score_r;
    logic                    r_point_l;
    logic                    r_point_r;
    logic                    r_game_over;
    logic [HW-1:0]           r_hold_cnt;
    logic [1:0]              r_guard_cnt;
    logic                    r_last_r;      // 1 when the last point went to the right player

    logic [BIT_OF_WIDTH-1:0] w_x;
    logic [BIT_OF_WIDTH-1:0] w_y;
    logic [BW-1:0]           w_y_ext;
    logic [BW-1:0]           w_lpad_lo;
    logic [BW-1:0]           w_lpad_hi;
    logic [BW-1:0]           w_rpad_lo;
    logic [BW-1:0]           w_rpad_hi;
    logic                    w_on_lpad;
    logic                    w_on_rpad;
    logic [3:0]              w_dir_next;
    logic                    w_miss_l;      // ball reached column 0, right scores
    logic                    w_miss_r;      // ball reached column WIDTH-1, left scores
    logic                    w_won;

    assign w_x = io_bus.pos[2*BIT_OF_WIDTH-1:BIT_OF_WIDTH];
    assign w_y = io_bus.pos[BIT_OF_WIDTH-1:0];

    // Paddle spans computed one bit wider so a paddle near the bottom row
    // does not wrap around to cover row 0.
    assign w_y_ext   = {1'b0, w_y};
    assign w_lpad_lo = {1'b0, io_bus.lpad_y};
    assign w_lpad_hi = w_lpad_lo + BW'(PADDLE_LEN - 1);
    assign w_rpad_lo = {1'b0, io_bus.rpad_y};
    assign w_rpad_hi = w_rpad_lo + BW'(PADDLE_LEN - 1);
    assign w_on_lpad = (w_y_ext >= w_lpad_lo) && (w_y_ext <= w_lpad_hi);
    assign w_on_rpad = (w_y_ext >= w_rpad_lo) && (w_y_ext <= w_rpad_hi);

    assign w_miss_l = (w_x == '0);
    assign w_miss_r = (w_x == BIT_OF_WIDTH'(WIDTH - 1));
    assign w_won    = r_last_r ? (r_score_r == 4'(WIN_SCORE)) : (r_score_l == 4'(WIN_SCORE));

    // Axis reflections are independent, so a corner hit flips both.
    always_comb begin
        w_dir_next = r_dir;
        if (r_dir[1:0] == D_POS && w_y == BIT_OF_WIDTH'(WIDTH - 1)) begin
            w_dir_next[1:0] = D_NEG;
        end else if (r_dir[1:0] == D_NEG && w_y == '0) begin
            w_dir_next[1:0] = D_POS;
        end
        if (r_dir[3:2] == D_NEG && w_x == BIT_OF_WIDTH'(1) && w_on_lpad) begin
            w_dir_next[3:2] = D_POS;
        end else if (r_dir[3:2] == D_POS && w_x == BIT_OF_WIDTH'(WIDTH - 2) && w_on_rpad) begin
            w_dir_next[3:2] = D_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dir       <= SERVE0;
            r_vector    <= '0;
            r_en        <= 1'b0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_point_l   <= 1'b0;
            r_point_r   <= 1'b0;
            r_game_over <= 1'b0;
            r_hold_cnt  <= '0;
            r_guard_cnt <= '0;
            r_last_r    <= 1'b0;
        end else begin
            r_point_l <= 1'b0;
            r_point_r <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_en     <= 1'b0;
                    r_vector <= '0;
                    if (io_bus.start) begin
                        r_dir      <= SERVE0;
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_en        <= 1'b0;
                    r_vector    <= '0;
                    r_guard_cnt <= '0;
                    if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        r_en    <= 1'b1;
                        r_state <= S_PLAY;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    // A miss outranks a tick arriving in the same cycle.
                    if (w_miss_l || w_miss_r) begin
                        r_en        <= 1'b0;
                        r_vector    <= '0;
                        r_guard_cnt <= '0;
                        r_last_r    <= w_miss_l;
                        r_state     <= S_POINT;
                        if (w_miss_l) begin
                            r_point_r <= 1'b1;
                            if (r_score_r != 4'(WIN_SCORE)) r_score_r <= r_score_r + 1'b1;
                        end else begin
                            r_point_l <= 1'b1;
                            if (r_score_l != 4'(WIN_SCORE)) r_score_l <= r_score_l + 1'b1;
                        end
                    end else if (io_bus.tick && r_guard_cnt == '0) begin
                        r_dir       <= w_dir_next;
                        r_vector    <= w_dir_next;
                        r_guard_cnt <= 2'd2;
                    end else begin
                        // Vector is a single-cycle step; the guard keeps
                        // ticks out until the moved position has settled.
                        r_vector <= '0;
                        if (r_guard_cnt != '0) r_guard_cnt <= r_guard_cnt - 1'b1;
                    end
                end
                S_POINT: begin
                    r_en     <= 1'b0;
                    r_vector <= '0;
                    if (w_won) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else begin
                        // Serve toward the player who conceded.
                        r_dir      <= {(r_last_r ? D_NEG : D_POS), D_POS};
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end
                end
                S_OVER: begin
                    r_en     <= 1'b0;
                    r_vector <= '0;
                    if (io_bus.start) begin
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_dir       <= SERVE0;
                        r_hold_cnt  <= '0;
                        r_game_over <= 1'b0;
                        r_state     <= S_HOLD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.vector    = r_vector;
    assign io_bus.en        = r_en;
    assign io_bus.score_l   = r_score_l;
    assign io_bus.score_r   = r_score_r;
    assign io_bus.point_l   = r_point_l;
    assign io_bus.point_r   = r_point_r;
    assign io_bus.game_over = r_game_over;
endmodule

// File: tb/tb_ball_dir_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ball_dir_ctrl
// Directed testbench for ball_dir_ctrl: a table of bounce vectors plus
// hand-written sequences for start/hold, misses, game over, tick guard and
// asynchronous reset. Inputs change 1 time unit after each rising edge and
// outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_ball_dir_ctrl;
    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    ball_dir_ctrl_if #(.BIT_OF_WIDTH(3)) bus ();

    ball_dir_ctrl #(
        .WIDTH(8), .BIT_OF_WIDTH(3), .PADDLE_LEN(3), .WIN_SCORE(9), .HOLD_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        string      name;
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] lpad;
        logic [2:0] rpad;
        logic [3:0] exp_vec;
    } vec_t;

    vec_t tbl [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end else begin
            $display("ok   %s val=%0h", name, act);
        end
    endtask

    task automatic set_pos(input int x, input int y);
        bus.pos = {3'(x), 3'(y)};
    endtask

    task automatic wait_play();
        for (int i = 0; i < 20; i++) begin
            if (bus.en === 1'b1) break;
            step();
        end
        check("wait_play_en", int'(bus.en), 1);
    endtask

    // One accepted tick: vector valid for one cycle, then zero, then guard clears.
    task automatic do_tick(input string name, input logic [3:0] exp_vec);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        check(name, int'(bus.vector), int'(exp_vec));
        step();
        check({name, "_vec0"}, int'(bus.vector), 0);
        step();
    endtask

    task automatic miss(input int x);
        set_pos(x, 2);
        step();
        set_pos(4, 4);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus.start  = 1'b0;
        bus.tick   = 1'b0;
        bus.lpad_y = 3'd0;
        bus.rpad_y = 3'd0;
        set_pos(4, 4);

        tbl[0]  = '{"wall_bottom",     3'd4, 3'd7, 3'd0, 3'd0, 4'b0111};
        tbl[1]  = '{"corner_rpad",     3'd6, 3'd0, 3'd0, 3'd0, 4'b1101};
        tbl[2]  = '{"wall_bottom_l",   3'd3, 3'd7, 3'd0, 3'd0, 4'b1111};
        tbl[3]  = '{"lpad_hit",        3'd1, 3'd3, 3'd2, 3'd0, 4'b0111};
        tbl[4]  = '{"rpad_hit_bottom", 3'd6, 3'd7, 3'd0, 3'd5, 4'b1111};
        tbl[5]  = '{"lpad_miss",       3'd1, 3'd3, 3'd5, 3'd0, 4'b1111};
        tbl[6]  = '{"wall_top",        3'd2, 3'd0, 3'd0, 3'd0, 4'b1101};
        tbl[7]  = '{"lpad_last_row",   3'd1, 3'd4, 3'd2, 3'd0, 4'b0101};
        tbl[8]  = '{"rpad_corner",     3'd6, 3'd7, 3'd0, 3'd5, 4'b1111};
        tbl[9]  = '{"lpad_above",      3'd1, 3'd1, 3'd2, 3'd0, 4'b1111};
        tbl[10] = '{"lpad_no_wrap",    3'd1, 3'd0, 3'd6, 3'd0, 4'b1101};
        tbl[11] = '{"lpad_low_corner", 3'd1, 3'd7, 3'd6, 3'd0, 4'b0111};

        // Reset values
        rst_n = 1'b0;
        #12;
        check("rst_en",        int'(bus.en), 0);
        check("rst_vector",    int'(bus.vector), 0);
        check("rst_score_l",   int'(bus.score_l), 0);
        check("rst_score_r",   int'(bus.score_r), 0);
        check("rst_game_over", int'(bus.game_over), 0);
        rst_n = 1'b1;
        step();
        check("idle_en", int'(bus.en), 0);

        // Start: HOLD_CYCLES cycles of en=0, then PLAY
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_en_%0d", i), int'(bus.en), 0);
            step();
        end
        check("play_en", int'(bus.en), 1);
        do_tick("first_tick", 4'b0101);

        // Bounce table
        foreach (tbl[i]) begin
            set_pos(int'(tbl[i].x), int'(tbl[i].y));
            bus.lpad_y = tbl[i].lpad;
            bus.rpad_y = tbl[i].rpad;
            do_tick(tbl[i].name, tbl[i].exp_vec);
        end
        bus.lpad_y = 3'd0;
        bus.rpad_y = 3'd0;
        set_pos(4, 4);

        // Right scores (ball at column 0), tick in the same cycle is ignored
        bus.tick = 1'b1;
        miss(0);
        bus.tick = 1'b0;
        check("miss_l_point_r", int'(bus.point_r), 1);
        check("miss_l_point_l", int'(bus.point_l), 0);
        check("miss_l_score_r", int'(bus.score_r), 1);
        check("miss_l_en",      int'(bus.en), 0);
        check("miss_l_vector",  int'(bus.vector), 0);
        step();
        check("point_pulse_end", int'(bus.point_r), 0);
        check("point_en",        int'(bus.en), 0);
        wait_play();
        do_tick("serve_left", 4'b1101);

        // Left scores (ball at column WIDTH-1)
        miss(7);
        check("miss_r_point_l", int'(bus.point_l), 1);
        check("miss_r_score_l", int'(bus.score_l), 1);
        step();
        wait_play();
        do_tick("serve_right", 4'b0101);

        // Eight more right points reach WIN_SCORE
        for (int i = 0; i < 8; i++) begin
            wait_play();
            miss(0);
            step();
        end
        check("over_game_over", int'(bus.game_over), 1);
        check("over_score_r",   int'(bus.score_r), 9);
        check("over_score_l",   int'(bus.score_l), 1);

        // OVER ignores ticks and edge positions
        bus.tick = 1'b1;
        set_pos(0, 3);
        step();
        step();
        step();
        bus.tick = 1'b0;
        set_pos(4, 4);
        check("over_en",       int'(bus.en), 0);
        check("over_vector",   int'(bus.vector), 0);
        check("over_score_hold", int'(bus.score_r), 9);

        // Restart
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_score_l",   int'(bus.score_l), 0);
        check("restart_score_r",   int'(bus.score_r), 0);
        check("restart_game_over", int'(bus.game_over), 0);
        check("restart_en",        int'(bus.en), 0);
        wait_play();

        // Consecutive ticks: only the first moves
        bus.tick = 1'b1;
        step();
        check("guard_t0", int'(bus.vector), 5);
        step();
        check("guard_t1", int'(bus.vector), 0);
        step();
        check("guard_t2", int'(bus.vector), 0);
        bus.tick = 1'b0;
        step();

        // Score something, then reset asynchronously mid-cycle while vector is live
        miss(7);
        step();
        wait_play();
        check("pre_rst_score_l", int'(bus.score_l), 1);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        check("pre_rst_vector", int'(bus.vector), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_en",      int'(bus.en), 0);
        check("async_rst_vector",  int'(bus.vector), 0);
        check("async_rst_score_l", int'(bus.score_l), 0);
        #10;
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
